// File: rtl/sb_forward_if.sv
// ---------------------------------------------------------------------------
// sb_forward_if
// Bus bundle for the store buffer: the store allocation channel (push), the
// drain channel toward the cache write port (pop) and the load forwarding
// lookup (query/fwd). Signal suffixes are relative to the store buffer.
//
// Handshake rule shared by push and pop channels: a transfer happens on a
// rising clock edge where valid and ready are both 1. The source keeps its
// payload stable while valid=1 and ready=0; ready never waits on valid.
//
// Modports:
//   slave  - the store buffer (sb_forward)
//   master - the pipeline / cache side driving pushes and accepting pops
// ---------------------------------------------------------------------------
interface sb_forward_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // store allocation channel
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [ADDR_WIDTH-1:0] push_addr_i;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic [STRB_W-1:0]     push_strb_i;

  // drain channel
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [ADDR_WIDTH-1:0] pop_addr_o;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic [STRB_W-1:0]     pop_strb_o;

  // load forwarding lookup
  logic [ADDR_WIDTH-1:0] query_addr_i;
  logic [DATA_WIDTH-1:0] fwd_data_o;
  logic [STRB_W-1:0]     fwd_strb_o;

  modport slave (
    input  push_valid_i, push_addr_i, push_data_i, push_strb_i,
    output push_ready_o,
    output pop_valid_o, pop_addr_o, pop_data_o, pop_strb_o,
    input  pop_ready_i,
    input  query_addr_i,
    output fwd_data_o, fwd_strb_o
  );

  modport master (
    output push_valid_i, push_addr_i, push_data_i, push_strb_i,
    input  push_ready_o,
    input  pop_valid_o, pop_addr_o, pop_data_o, pop_strb_o,
    output pop_ready_i,
    output query_addr_i,
    input  fwd_data_o, fwd_strb_o
  );
endinterface

// File: rtl/sb_forward.sv
// ---------------------------------------------------------------------------
// sb_forward
// Store buffer with store-to-load forwarding. Stores are allocated in program
// order, later marked committed by the commit stage, and drained oldest-first
// to the cache. Loads look up the buffer combinationally and receive, per
// byte, the data of the youngest matching store.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   flush_i           - drop every uncommitted entry
//   commit_i          - commit the oldest uncommitted entry
//   bus (slave)       - push / pop / query-forward channels (sb_forward_if)
//   full_o, empty_o   - occupancy flags
//   cnt_o             - number of valid entries (0..SB_SIZE)
//
// Storage is a circular FIFO with three pointers:
//   head  - oldest entry (next to drain)
//   cptr  - oldest uncommitted entry (one past the youngest committed)
//   tail  - next free slot
// Committed entries always form a contiguous run starting at head.
// ---------------------------------------------------------------------------
module sb_forward #(
  parameter int SB_SIZE    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     commit_i,
  sb_forward_if.slave              bus,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(SB_SIZE):0] cnt_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(SB_SIZE);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SB_SIZE);

  // entry payload (not reset; validity comes from the pointers/count)
  logic [ADDR_WIDTH-1:0] addr_q [SB_SIZE];
  logic [DATA_WIDTH-1:0] data_q [SB_SIZE];
  logic [STRB_W-1:0]     strb_q [SB_SIZE];

  // control state
  logic [SB_SIZE-1:0] cflag_q, cflag_d;   // per-entry committed flag
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   cptr_q, cptr_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // valid entries
  logic [CNT_W-1:0]   ccnt_q, ccnt_d;     // committed entries

  logic pop_valid;
  logic do_push, do_pop, do_commit;

  // -------------------------------------------------------------------------
  // Status and handshake decode, all from registered state
  // -------------------------------------------------------------------------
  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  assign bus.push_ready_o = !full_o;
  assign pop_valid        = !empty_o && cflag_q[head_q];
  assign bus.pop_valid_o  = pop_valid;

  // Pop outputs read zero while the buffer is empty so stale payload never
  // leaks onto the cache port.
  assign bus.pop_addr_o = empty_o ? '0 : addr_q[head_q];
  assign bus.pop_data_o = empty_o ? '0 : data_q[head_q];
  assign bus.pop_strb_o = empty_o ? '0 : strb_q[head_q];

  assign do_pop    = pop_valid && bus.pop_ready_i;
  // Only an entry that was uncommitted at the start of the cycle can commit;
  // this keeps a same-cycle push out of reach of commit_i.
  assign do_commit = commit_i && (cnt_q != ccnt_q);
  assign do_push   = bus.push_valid_i && !full_o && !flush_i;

  // -------------------------------------------------------------------------
  // Next-state: pop, then commit, then either flush or push
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    cptr_d  = cptr_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    ccnt_d  = ccnt_q;
    cflag_d = cflag_q;

    if (do_pop) begin
      cflag_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
      ccnt_d          = ccnt_d - CNT_ONE;
    end

    if (do_commit) begin
      cflag_d[cptr_q] = 1'b1;
      cptr_d          = cptr_q + PTR_ONE;
      ccnt_d          = ccnt_d + CNT_ONE;
    end

    if (flush_i) begin
      // Only the committed run survives, so occupancy collapses to it.
      tail_d = cptr_d;
      cnt_d  = ccnt_d;
    end else begin
      if (do_pop) begin
        cnt_d = cnt_d - CNT_ONE;
      end
      if (do_push) begin
        tail_d = tail_q + PTR_ONE;
        cnt_d  = cnt_d + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      cptr_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      cflag_q <= '0;
    end else begin
      head_q  <= head_d;
      cptr_q  <= cptr_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ccnt_q  <= ccnt_d;
      cflag_q <= cflag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= bus.push_addr_i;
      data_q[tail_q] <= bus.push_data_i;
      strb_q[tail_q] <= bus.push_strb_i;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding: walk entries oldest to youngest so a younger match overwrites
  // an older one byte by byte. Uses start-of-cycle state only.
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]      fwd_idx;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [STRB_W-1:0]     fwd_strb;

  always_comb begin
    fwd_idx  = '0;
    fwd_data = '0;
    fwd_strb = '0;
    for (int k = 0; k < SB_SIZE; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < cnt_q) &&
          (addr_q[fwd_idx][ADDR_WIDTH-1:OFF_W] == bus.query_addr_i[ADDR_WIDTH-1:OFF_W])) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[fwd_idx][b]) begin
            fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
            fwd_strb[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign bus.fwd_data_o = fwd_data;
  assign bus.fwd_strb_o = fwd_strb;

endmodule
